// File: rtl/avg_pool_pkg.sv
// Shared types and helpers for the 2x2 average-pooling sequencer.
// Contents: FSM state enum, pool factor/shift constants, address-width helpers.
package avg_pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        ACC,
        WR,
        DONE
    } avg_pool_state_t;

    localparam int unsigned POOL       = 2;
    localparam int unsigned POOL_SHIFT = 2;

    // $clog2 that never returns 0, so degenerate sizes still give a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rd_aw(input int unsigned ch, input int unsigned w,
                                          input int unsigned h);
        return clog2_min1(ch * w * h);
    endfunction

    function automatic int unsigned wr_aw(input int unsigned ch, input int unsigned w,
                                          input int unsigned h);
        return clog2_min1(ch * (w / POOL) * (h / POOL));
    endfunction

endpackage

// File: rtl/avg_pool_addr_gen.sv
// Window counters (ocol fastest, then orow, then ch) and address generation.
// Ports: clk, reset (async, active-high), step (advance to next window),
//        tap (dy,dx of the read being issued), rd_addr_c / wr_addr_c
//        (combinational addresses for the current window), last_window_c.
module avg_pool_addr_gen
    import avg_pool_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned NUM_CH = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   step,
    input  logic [1:0]                             tap,
    output logic [rd_aw(NUM_CH, IMG_W, IMG_H)-1:0] rd_addr_c,
    output logic [wr_aw(NUM_CH, IMG_W, IMG_H)-1:0] wr_addr_c,
    output logic                                   last_window_c
);

    localparam int unsigned RD_AW  = rd_aw(NUM_CH, IMG_W, IMG_H);
    localparam int unsigned WR_AW  = wr_aw(NUM_CH, IMG_W, IMG_H);
    localparam int unsigned OW     = IMG_W / POOL;
    localparam int unsigned OH     = IMG_H / POOL;
    localparam int unsigned PLANE  = IMG_W * IMG_H;
    localparam int unsigned OPLANE = OW * OH;
    localparam int unsigned OCOL_W = clog2_min1(OW);
    localparam int unsigned OROW_W = clog2_min1(OH);
    localparam int unsigned CH_W   = clog2_min1(NUM_CH);

    logic [OCOL_W-1:0] ocol;
    logic [OROW_W-1:0] orow;
    logic [CH_W-1:0]   ch;

    logic ocol_last, orow_last, ch_last;

    always_comb begin
        ocol_last     = (ocol == OCOL_W'(OW - 1));
        orow_last     = (orow == OROW_W'(OH - 1));
        ch_last       = (ch == CH_W'(NUM_CH - 1));
        last_window_c = ocol_last && orow_last && ch_last;
        // tap[1] selects the lower input row, tap[0] the right-hand column
        rd_addr_c = RD_AW'(32'(ch) * PLANE
                         + (32'(orow) * POOL + 32'(tap[1])) * IMG_W
                         + 32'(ocol) * POOL + 32'(tap[0]));
        wr_addr_c = WR_AW'(32'(ch) * OPLANE + 32'(orow) * OW + 32'(ocol));
    end

    // Counters wrap to zero after the last window, so IDLE always sees window 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocol <= '0;
            orow <= '0;
            ch   <= '0;
        end else if (step) begin
            if (ocol_last) begin
                ocol <= '0;
                if (orow_last) begin
                    orow <= '0;
                    ch   <= ch_last ? '0 : ch + CH_W'(1);
                end else begin
                    orow <= orow + OROW_W'(1);
                end
            end else begin
                ocol <= ocol + OCOL_W'(1);
            end
        end
    end

endmodule

// File: rtl/avg_pool_sequencer.sv
// 2x2 average-pooling controller streaming NUM_CH maps from a sync-read image
// RAM into an output RAM, one window every 6 cycles.
// Ports: clk, reset (async, active-high), enable (global stall), start (pass
//        request), busy, finished_pool (completion pulse), rd_en/rd_addr/rd_data
//        (image RAM, data one cycle after rd_en), wr_en/wr_addr/wr_data (output RAM).
module avg_pool_sequencer
    import avg_pool_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   finished_pool,
    output logic                                   rd_en,
    output logic [rd_aw(NUM_CH, IMG_W, IMG_H)-1:0] rd_addr,
    input  logic signed [DATA_W-1:0]               rd_data,
    output logic                                   wr_en,
    output logic [wr_aw(NUM_CH, IMG_W, IMG_H)-1:0] wr_addr,
    output logic signed [OUT_W-1:0]                wr_data
);

    localparam int unsigned RD_AW = rd_aw(NUM_CH, IMG_W, IMG_H);
    localparam int unsigned WR_AW = wr_aw(NUM_CH, IMG_W, IMG_H);
    localparam int unsigned ACC_W = DATA_W + 2;

    if ((IMG_W % POOL) != 0) begin : g_bad_w
        $error("IMG_W must be even");
    end
    if ((IMG_H % POOL) != 0) begin : g_bad_h
        $error("IMG_H must be even");
    end
    if (OUT_W < DATA_W) begin : g_bad_ow
        $error("OUT_W must be >= DATA_W");
    end

    avg_pool_state_t          state;
    logic                     rd_en_q, wr_en_q, done_q, last_q;
    logic signed [ACC_W-1:0]  acc, acc_next, acc_avg;
    logic [1:0]               tap_c;
    logic                     step_c;
    logic [RD_AW-1:0]         rd_addr_c;
    logic [WR_AW-1:0]         wr_addr_c;
    logic                     last_window_c;

    avg_pool_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .NUM_CH(NUM_CH)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .step         (step_c),
        .tap          (tap_c),
        .rd_addr_c    (rd_addr_c),
        .wr_addr_c    (wr_addr_c),
        .last_window_c(last_window_c)
    );

    // Tap of the read issued on leaving the current state; counters advance on
    // leaving ACC so WR can already address the next window's first read.
    always_comb begin
        acc_next = acc + ACC_W'(rd_data);
        acc_avg  = acc_next >>> POOL_SHIFT;
        step_c   = enable && (state == ACC);
        case (state)
            RD0:     tap_c = 2'd1;
            RD1:     tap_c = 2'd2;
            RD2:     tap_c = 2'd3;
            default: tap_c = 2'd0;
        endcase
    end

    // Stalls must not strobe the RAMs nor let the completion pulse escape.
    assign rd_en         = rd_en_q && enable;
    assign wr_en         = wr_en_q && enable;
    assign finished_pool = done_q && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            acc     <= '0;
        end else if (enable) begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RD0;
                        busy    <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_addr <= rd_addr_c;
                    end
                end
                RD0: begin
                    acc     <= '0;
                    state   <= RD1;
                    rd_en_q <= 1'b1;
                    rd_addr <= rd_addr_c;
                end
                RD1: begin
                    acc     <= acc_next;
                    state   <= RD2;
                    rd_en_q <= 1'b1;
                    rd_addr <= rd_addr_c;
                end
                RD2: begin
                    acc     <= acc_next;
                    state   <= RD3;
                    rd_en_q <= 1'b1;
                    rd_addr <= rd_addr_c;
                end
                RD3: begin
                    acc   <= acc_next;
                    state <= ACC;
                end
                ACC: begin
                    acc     <= acc_next;
                    wr_data <= OUT_W'(acc_avg);
                    wr_addr <= wr_addr_c;
                    last_q  <= last_window_c;
                    wr_en_q <= 1'b1;
                    state   <= WR;
                end
                WR: begin
                    if (last_q) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state   <= RD0;
                        rd_en_q <= 1'b1;
                        rd_addr <= rd_addr_c;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avg_pool_sequencer.sv
// Directed bench for avg_pool_sequencer: one 28x28x1 instance and one 28x28x2
// instance, each with a synchronous-read image RAM model and a write monitor.
module tb_avg_pool_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, start1, start2, mon_clr;

    logic              busy1, fin1, rd_en1, wr_en1;
    logic [9:0]        rd_addr1;
    logic [7:0]        wr_addr1;
    logic signed [7:0] rd_data1 = '0;
    logic signed [15:0] wr_data1;

    logic              busy2, fin2, rd_en2, wr_en2;
    logic [10:0]       rd_addr2;
    logic [8:0]        wr_addr2;
    logic signed [7:0] rd_data2 = '0;
    logic signed [15:0] wr_data2;

    logic signed [7:0] img1 [0:783];
    logic signed [7:0] img2 [0:1567];
    int got1 [0:195];
    int ref1 [0:195];
    int got2 [0:391];

    int total = 0;
    int bad   = 0;

    avg_pool_sequencer #(.IMG_W(28), .IMG_H(28), .NUM_CH(1), .DATA_W(8), .OUT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .start(start1), .busy(busy1),
        .finished_pool(fin1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    avg_pool_sequencer #(.IMG_W(28), .IMG_H(28), .NUM_CH(2), .DATA_W(8), .OUT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .start(start2), .busy(busy2),
        .finished_pool(fin2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
    );

    // Image RAMs: data appears the cycle after rd_en and holds otherwise.
    always @(posedge clk) if (rd_en1) rd_data1 <= img1[rd_addr1];
    always @(posedge clk) if (rd_en2) rd_data2 <= img2[rd_addr2];

    int m1_wr, m1_ord, m1_busy, m1_fin, m1_both, m1_stall, m1_rd;
    int m1_cyc, m1_start, m1_fin_cyc, m1_lastwr;
    int m2_wr, m2_ord, m2_busy, m2_fin, m2_both;

    always @(negedge clk) begin
        if (mon_clr) begin
            m1_wr = 0; m1_ord = 0; m1_busy = 0; m1_fin = 0; m1_both = 0;
            m1_stall = 0; m1_rd = 0; m1_cyc = 0; m1_start = 0;
            m1_fin_cyc = 0; m1_lastwr = 0;
            for (int i = 0; i < 196; i++) got1[i] = -9999;
        end else begin
            m1_cyc++;
            if (start1 && enable && !busy1) m1_start = m1_cyc;
            if (busy1) m1_busy++;
            if (rd_en1) m1_rd++;
            if (rd_en1 && wr_en1) m1_both++;
            if (!enable && (rd_en1 || wr_en1)) m1_stall++;
            if (wr_en1) begin
                if (int'(wr_addr1) != m1_wr) m1_ord++;
                if (wr_addr1 < 8'd196) got1[wr_addr1] = int'(wr_data1);
                m1_wr++;
                m1_lastwr = m1_cyc;
            end
            if (fin1) begin
                m1_fin++;
                m1_fin_cyc = m1_cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            m2_wr = 0; m2_ord = 0; m2_busy = 0; m2_fin = 0; m2_both = 0;
            for (int i = 0; i < 392; i++) got2[i] = -9999;
        end else begin
            if (busy2) m2_busy++;
            if (rd_en2 && wr_en2) m2_both++;
            if (wr_en2) begin
                if (int'(wr_addr2) != m2_wr) m2_ord++;
                if (wr_addr2 < 9'd392) got2[wr_addr2] = int'(wr_data2);
                m2_wr++;
            end
            if (fin2) m2_fin++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        tick(1);
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        tick(1);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_fin(input int sel, input int budget);
        int f0;
        f0 = (sel == 1) ? m1_fin : m2_fin;
        for (int i = 0; i < budget; i++) begin
            if (((sel == 1) ? m1_fin : m2_fin) != f0) break;
            @(negedge clk);
        end
        check("fin_timeout", ((sel == 1) ? m1_fin : m2_fin) - f0, 1);
        repeat (5) @(negedge clk);
    endtask

    // One pass on the single-channel instance, optionally stalled mid-pass.
    task automatic run_pass1(input int stall_at, input int stall_len);
        clear_mon();
        pulse_start(1);
        if (stall_len > 0) begin
            tick(stall_at);
            enable = 1'b0;
            tick(stall_len);
            enable = 1'b1;
        end
        wait_fin(1, 3000);
    endtask

    function automatic int count_diff1();
        int n = 0;
        for (int i = 0; i < 196; i++) if (got1[i] != ref1[i]) n++;
        return n;
    endfunction

    initial begin
        int n;
        reset = 1'b1; enable = 1'b1; start1 = 1'b0; start2 = 1'b0; mon_clr = 1'b1;
        for (int i = 0; i < 784; i++) img1[i] = '0;
        for (int i = 0; i < 1568; i++) img2[i] = '0;

        // Reset values while reset is held, then 50 idle cycles.
        @(negedge clk);
        check("rst_busy", int'(busy1), 0);
        check("rst_fin", int'(fin1), 0);
        check("rst_strobes", int'(rd_en1) + int'(wr_en1), 0);
        check("rst_rd_addr", int'(rd_addr1), 0);
        check("rst_wr_addr", int'(wr_addr1), 0);
        check("rst_wr_data", int'(wr_data1), 0);
        tick(2);
        reset = 1'b0;
        mon_clr = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_rd", m1_rd, 0);
        check("idle_wr", m1_wr, 0);
        check("idle_busy", m1_busy, 0);
        check("idle_fin", m1_fin, 0);

        // Uniform image of 126.
        for (int i = 0; i < 784; i++) img1[i] = 8'sd126;
        run_pass1(0, 0);
        n = 0;
        for (int i = 0; i < 196; i++) if (got1[i] != 126) n++;
        check("uni_data", n, 0);
        check("uni_wr_cnt", m1_wr, 196);
        check("uni_order", m1_ord, 0);
        check("uni_busy", m1_busy, 1176);
        check("uni_fin_cnt", m1_fin, 1);
        check("uni_fin_after_wr", m1_fin_cyc - m1_lastwr, 1);
        check("uni_latency", m1_fin_cyc - m1_start, 1177);
        check("uni_rd_wr_overlap", m1_both, 0);

        // Pattern image with three hand-computed windows.
        for (int i = 0; i < 784; i++) img1[i] = 8'((i * 37 + 11) % 256);
        img1[0] = -8'sd1;  img1[1] = -8'sd1;  img1[28] = -8'sd1;  img1[29] = -8'sd2;
        img1[178] = 8'sd4; img1[179] = 8'sd40; img1[206] = 8'sd19; img1[207] = 8'sd79;
        img1[754] = -8'sd128; img1[755] = -8'sd128; img1[782] = -8'sd128; img1[783] = -8'sd128;
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < 14; c++) begin
                int s;
                s = int'(img1[(2*r)*28 + 2*c]) + int'(img1[(2*r)*28 + 2*c + 1])
                  + int'(img1[(2*r+1)*28 + 2*c]) + int'(img1[(2*r+1)*28 + 2*c + 1]);
                ref1[r*14 + c] = s >>> 2;
            end
        end
        run_pass1(0, 0);
        check("win_neg_floor", got1[0], -2);
        check("win_35", got1[47], 35);
        check("win_min", got1[195], -128);
        check("pat_data", count_diff1(), 0);

        // Stall of 10 cycles mid-pass.
        run_pass1(300, 10);
        check("stall_strobes", m1_stall, 0);
        check("stall_latency", m1_fin_cyc - m1_start, 1187);
        check("stall_fin_cnt", m1_fin, 1);
        check("stall_data", count_diff1(), 0);
        check("stall_order", m1_ord, 0);

        // Reset mid-pass, then a fresh full pass.
        clear_mon();
        pulse_start(1);
        tick(200);
        reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy1), 0);
        tick(2);
        reset = 1'b0;
        repeat (1300) @(negedge clk);
        check("midrst_no_fin", m1_fin, 0);
        run_pass1(0, 0);
        check("post_rst_busy", m1_busy, 1176);
        check("post_rst_data", count_diff1(), 0);
        check("post_rst_fin_cnt", m1_fin, 1);

        // Two channels with a start pulse ignored mid-pass.
        for (int i = 0; i < 784; i++) img2[i] = 8'sd10;
        for (int i = 784; i < 1568; i++) img2[i] = -8'sd3;
        clear_mon();
        pulse_start(2);
        tick(500);
        pulse_start(2);
        wait_fin(2, 5000);
        repeat (50) @(negedge clk);
        n = 0;
        for (int i = 0; i < 392; i++) if (got2[i] != ((i < 196) ? 10 : -3)) n++;
        check("ch2_data", n, 0);
        check("ch2_wr_cnt", m2_wr, 392);
        check("ch2_order", m2_ord, 0);
        check("ch2_fin_cnt", m2_fin, 1);
        check("ch2_busy", m2_busy, 2352);
        check("ch2_overlap", m2_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
